// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accept a request, hold it LATENCY cycles,
// then present the response until the requester takes it. Word array with byte-lane writes.
module mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and a raised valid holds its payload until the transfer.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN      = 33'd1 << (DEPTH_LOG2 + 2);
  localparam logic [3:0]  WAIT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [31:0]             mem_q [DEPTH];

  logic [31:0]             off;
  logic                    in_range;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    accept;

  assign off      = req_addr - BASE;
  assign in_range = (req_addr >= BASE) && ({1'b0, off} < SPAN);
  assign idx      = off[DEPTH_LOG2+1:2];
  assign accept   = (state_q == IDLE) && req_valid && !rst;

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rdata_d = (in_range && !req_wen) ? mem_q[idx] : 32'd0;
          err_d   = !in_range;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        // The first RESP cycle registers valid; the response is offered from the next one.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (resp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array contents survive reset; a write commits on its accept edge.
  always_ff @(posedge clk) begin
    if (accept && req_wen && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wmask[b]) mem_q[idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus random traffic against a
// word-array reference model, and a latency/throughput sweep on extra instances.
module tb_mem_responder;

  localparam int          LAT  = 2;
  localparam int          DL   = 6;
  localparam int          NW   = 1 << DL;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wmask = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  dbg_state;

  logic        sw_valid = 1'b0;
  logic        sw_on = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic rst_prev = 1'b0;

  logic [31:0] mdl [NW];
  logic [32:0] exp_q [$];

  mem_responder #(.DEPTH_LOG2(DL), .BASE(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
  );

  // clock / reset bookkeeping
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rst;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: flat word array, range test on 64-bit arithmetic.
  task automatic model_apply(input logic wen, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] mask);
    longint a = {32'b0, addr};
    longint b = {32'b0, BASE};
    bit inr = (a >= b) && (a < b + 4 * NW);
    logic [31:0] rd = '0;
    int idx;
    if (inr) begin
      idx = int'((a - b) / 4);
      if (wen) begin
        for (int k = 0; k < 4; k++)
          if (mask[k]) mdl[idx][8*k +: 8] = wdata[8*k +: 8];
      end else begin
        rd = mdl[idx];
      end
    end
    exp_q.push_back({!inr, rd});
  endtask

  // scoreboard: every handshake must match the oldest expected response
  always @(negedge clk) begin
    if (rst_prev) begin
      chk("reset_resp", {resp_valid, resp_err, resp_rdata}, 34'd0);
    end else if (!rst && resp_valid === 1'b1 && resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", resp_valid, 0);
      end else begin
        chk("resp_data", {resp_err, resp_rdata}, exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", req_ready, 1);
  endtask

  task automatic txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] mask, input int bp,
                     output logic [31:0] rd, output logic er);
    int guard = 0;
    rd = '0;
    er = 1'b0;
    req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = mask;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
    if (guard >= 50) begin
      chk("req_ready_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    model_apply(wen, addr, wdata, mask);
    req_valid = 1'b0;
    req_wen = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_wmask = 4'($urandom);
    resp_ready = (bp == 0);
    guard = 0;
    while (resp_valid !== 1'b1 && guard < 40) begin @(posedge clk); #1; guard++; end
    if (guard >= 40) begin
      chk("resp_valid_timeout", 0, 1);
      resp_ready = 1'b1;
      exp_q.delete();
      return;
    end
    chk("latency", cyc - acc_cyc, LAT);
    rd = resp_rdata;
    er = resp_err;
    if (bp > 0) begin
      req_valid = 1'b1;
      for (int i = 0; i < bp; i++) begin
        @(posedge clk); #1;
        chk("bp_valid", resp_valid, 1);
        chk("bp_payload", {resp_err, resp_rdata}, {er, rd});
        chk("bp_req_ready", req_ready, 0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("post_hs_req_ready", req_ready, 1);
    chk("post_hs_valid", resp_valid, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(0, 9);
    case (r)
      0:       return BASE - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
      1:       return BASE + 32'(4 * NW) + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      2:       return $urandom;
      default: return BASE + 32'(4 * $urandom_range(0, NW - 1)) + 32'($urandom_range(0, 3));
    endcase
  endfunction

  // LATENCY sweep: two extra instances fed a continuous read stream.
  for (genvar g = 0; g < 2; g++) begin : g_sw
    localparam int L = (g == 0) ? 1 : 15;
    logic        rr, rv, re;
    logic [31:0] rd;
    logic [1:0]  st;
    int          acc_edge = -1;
    int          prev_acc = -1;
    logic        rv_prev = 1'b0;

    mem_responder #(.DEPTH_LOG2(DL), .BASE(BASE), .LATENCY(L)) u_sw (
      .clk(clk), .rst(rst),
      .req_valid(sw_valid), .req_ready(rr), .req_wen(1'b0),
      .req_addr(BASE), .req_wdata(32'd0), .req_wmask(4'd0),
      .resp_valid(rv), .resp_ready(1'b1),
      .resp_rdata(rd), .resp_err(re), .dbg_state(st)
    );

    always @(negedge clk) begin
      if (sw_on && !rst) begin
        if (rv === 1'b1 && rv_prev !== 1'b1) chk("sw_latency", cyc - acc_edge, L);
        if (sw_valid && rr === 1'b1) begin
          if (prev_acc >= 0) chk("sw_spacing", cyc + 1 - prev_acc, L + 2);
          prev_acc = cyc + 1;
          acc_edge = cyc + 1;
        end
      end
      rv_prev = rv;
    end
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          prev;

    do_reset();

    // fill the array so every later read has a known value
    for (int i = 0; i < NW; i++) txn(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 0, rd, er);

    txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
    chk("wr_err", er, 0);
    chk("wr_rdata", rd, 0);
    txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er);
    chk("rd_deadbeef", rd, 32'hDEAD_BEEF);
    chk("rd_err", er, 0);

    txn(1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, 0, rd, er);
    txn(1'b0, 32'h8000_0012, 32'h0, 4'h0, 0, rd, er);
    chk("rd_mask0101", rd, 32'hDE22_BE44);
    txn(1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'b0000, 0, rd, er);
    txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er);
    chk("rd_mask0000", rd, 32'hDE22_BE44);

    txn(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, rd, er);
    chk("oor_rd_err", er, 1);
    chk("oor_rd_rdata", rd, 0);
    txn(1'b1, BASE + 32'(4 * NW), 32'hFFFF_FFFF, 4'hF, 0, rd, er);
    chk("oor_wr_err", er, 1);
    chk("oor_wr_rdata", rd, 0);
    txn(1'b0, BASE, 32'h0, 4'h0, 0, rd, er);
    txn(1'b0, BASE + 32'(4 * (NW - 1)), 32'h0, 4'h0, 0, rd, er);

    txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 7, rd, er);
    chk("bp_rd", rd, 32'hDE22_BE44);

    // reset one cycle after accepting a write: write stays, response is dropped
    req_wen = 1'b1; req_addr = BASE + 32'd20; req_wdata = 32'hCAFE_F00D; req_wmask = 4'hF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    model_apply(1'b1, BASE + 32'd20, 32'hCAFE_F00D, 4'hF);
    exp_q.delete();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midwait_req_ready", req_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midwait_no_valid", resp_valid, 0);
    end
    txn(1'b0, BASE + 32'd20, 32'h0, 4'h0, 0, rd, er);
    chk("midwait_rd", rd, 32'hCAFE_F00D);

    // back-to-back spacing on the main instance
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      txn(1'b0, BASE + 32'(4 * i), 32'h0, 4'h0, 0, rd, er);
      if (prev >= 0) chk("spacing", acc_cyc - prev, LAT + 2);
      prev = acc_cyc;
    end

    for (int i = 0; i < 300; i++) begin
      txn(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom),
          ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0, rd, er);
    end

    @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);

    sw_on = 1'b1;
    sw_valid = 1'b1;
    repeat (90) @(posedge clk);
    #1;
    sw_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    sw_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the core's load/store path. Accepts one request at a time over a valid/ready handshake, holds it for a fixed programmable latency, then returns a response over a second valid/ready handshake. Backed by an internal word-addressed array with byte-lane write masking. Used as the on-chip data memory / simulation stand-in behind the LSU, so LSU bus timing can be exercised without DPI-C.

## Interface

Parameters:
- `DEPTH_LOG2`, 10: array holds 2^DEPTH_LOG2 32-bit words.
- `BASE`, 32'h8000_0000: byte address of word 0.
- `LATENCY`, 2: cycles from request accept to `resp_valid` high; legal range 1..15.

Ports:
- `clk`  in  1  single clock; everything is posedge.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_wen`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address; bits [1:0] ignored.
- `req_wdata`  in  32  write data.
- `req_wmask`  in  4  byte enables; bit i enables `req_wdata[8i+7:8i]`.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  requester takes the response.
- `resp_rdata`  out  32  read data; 0 for writes and errors.
- `resp_err`  out  1  address out of range.

## Operation

- States: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&`req_ready` (the accept edge), capture the response fields.
  - Go to RESP if LATENCY=1. Otherwise go to WAIT with counter=LATENCY-2.
- WAIT:
  - `req_ready`=0, `resp_valid`=0.
  - Counter decrements each cycle. At counter 0, go to RESP.
- RESP:
  - `resp_valid`=1. `resp_rdata` and `resp_err` are stable.
  - On `resp_valid`&`resp_ready`, go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Range check: in range iff BASE <= addr < BASE + 4·2^DEPTH_LOG2, compared as unsigned 32-bit values.
  - Index = (addr − BASE)[DEPTH_LOG2+1:2].
- Memory access happens at the accept edge:
  - Write, in range: update only the enabled byte lanes. `wmask`=0 is a legal no-op.
  - Read, in range: capture the array word into the response register.
  - Out of range: no array update. `resp_err`=1, `resp_rdata`=0.
- Write response: `resp_rdata`=0, `resp_err` set per the range check.
- A read in a later transaction always observes an earlier write.
- Request inputs are sampled only at the accept edge. Changes at other times are ignored.

## Timing

- Reset:
  - `rst` high at an edge gives state=IDLE, counter=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - `req_ready`=0 while `rst` is high; `req_ready`=1 from the first cycle after.
  - Array contents are not reset.
- Latency: accept at edge T, then `resp_valid` rises after edge T+LATENCY.
  - With `resp_ready` held high, the response handshakes at edge T+LATENCY+1.
  - `req_ready` returns 1 in the following cycle.
- Throughput with `resp_ready`=1: one transaction per LATENCY+2 cycles.
- Backpressure: `resp_valid`, `resp_rdata` and `resp_err` are held indefinitely while `resp_ready`=0.
- Reset mid-transaction:
  - A write already accepted stays committed.
  - A pending response is dropped; no `resp_valid` after reset.
- `req_valid` with `req_ready`=0 is not an accept. The requester must hold the request.
- All outputs are registered or decoded from state only. No combinational path from `req_*` or `resp_ready` to any output.

## Test plan

- Reset, then write addr 0x8000_0010, data 0xDEAD_BEEF, mask 4'hF. Then read the same address.
  - Write response: `resp_err`=0, `resp_rdata`=0.
  - Read response: `resp_rdata`=0xDEAD_BEEF, with `resp_valid` rising exactly LATENCY edges after the accept.
- Byte masking: from 0xDEAD_BEEF, write 0x1122_3344 with mask 4'b0101. Read back.
  - Expect 0xDE22_BE44. Repeat with mask 0; data is unchanged.
- Out of range: read 0x7FFF_FFFC, then write to BASE + 4·2^DEPTH_LOG2.
  - Both give `resp_err`=1, `resp_rdata`=0.
  - A read of word 0 and of the last word afterwards shows those words unchanged.
- Backpressure: hold `resp_ready`=0 for 7 cycles after `resp_valid` rises.
  - `resp_valid` and `resp_rdata` stay stable.
  - `req_ready` stays 0 even with `req_valid` high; no second accept.
  - Release: handshake, then `req_ready`=1 the next cycle.
- Reset mid-WAIT: accept a write, assert `rst` one cycle later.
  - `resp_valid` never rises and `req_ready` is 1 after reset.
  - A subsequent read returns the written data.
- LATENCY sweep at 1, 2 and 15, with back-to-back requests and `resp_ready`=1.
  - Accept-to-`resp_valid` distance equals LATENCY.
  - Transaction spacing is LATENCY+2 cycles.
